dsp_power_supervisor: RTL and testbench
=======================================

DSP_POWER_SUPERVISOR -- requirements
Module: dsp_power_supervisor

Interface
REQ-001 SHALL have ports: sysclk  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: board_enable  in  1  request to power both DSPs.
REQ-004 SHALL have ports: dsp0_state, dsp1_state  in  4 each  per-DSP power-sequencer state code; 4'b0000 = off, 4'b1001 = on.
REQ-005 SHALL have ports: dsp0_enable, dsp1_enable  out  1 each  enable to each DSP power sequencer.
REQ-006 SHALL have ports: all_on  out  1  both DSPs running.
REQ-007 SHALL have ports: fault  out  1  retries exhausted; latched.
REQ-008 SHALL have ports: fault_dsp  out  2  sticky fault mask; bit0 = DSP0, bit1 = DSP1.
REQ-009 SHALL have ports: retry_count  out  2  bring-up retries used.
REQ-010 SHALL have ports: sup_state  out  3  current supervisor state.

Function
REQ-011 SHALL use a 13-bit free-running prescaler that emits a 1-cycle tick when it equals 8191 (period 8192 sysclk).
REQ-012 SHALL use a 5-bit tick timer that clears on every state change and saturates at 31.
REQ-013 SHALL implement states: IDLE=000, BRINGUP0=001, STAGGER=010, BRINGUP1=011, RUN=100, COOLDOWN=101, FAULT=110, SHUTDOWN=111.
REQ-014 SHALL, in IDLE, drive both enables low, clear retry_count and fault_dsp, and go to BRINGUP0 when board_enable=1.
REQ-015 SHALL, in BRINGUP0, drive dsp0_enable=1; go to STAGGER when dsp0_state=on; at timer=20, set fault_dsp[0] and go to COOLDOWN.
REQ-016 SHALL, in STAGGER, hold dsp0_enable=1 and go to BRINGUP1 at timer=4; if dsp0_state leaves on, set fault_dsp[0] and go to COOLDOWN.
REQ-017 SHALL, in BRINGUP1, drive both enables=1; go to RUN when dsp1_state=on and dsp0_state=on; a dsp0_state drop sets bit0, and timer=20 sets bit1; either goes to COOLDOWN.
REQ-018 SHALL, in RUN, drive both enables=1 and all_on=1; any dsp state not on sets the matching fault_dsp bit(s) and goes to COOLDOWN.
REQ-019 SHALL, in COOLDOWN, drive both enables low; exit when (timer>=16 and both states=off) or timer=31; if a retry is permitted, increment retry_count and go to BRINGUP0, else go to FAULT.
REQ-020 SHALL, in FAULT, drive both enables low and fault=1; go to IDLE only when board_enable=0.
REQ-021 SHALL, in SHUTDOWN, drive both enables low and go to IDLE when both states=off or timer=31.
REQ-022 SHALL go to SHUTDOWN when board_enable=0 in BRINGUP0, STAGGER, BRINGUP1, RUN or COOLDOWN; this takes priority over fault attribution, and fault_dsp is not updated in that cycle.
REQ-023 SHALL register all outputs; they change in the cycle after the state transition.

Reset
REQ-024 SHALL, on reset, set state=IDLE, prescaler=0, timer=0, both enables=0, all_on=0, fault=0, fault_dsp=00, retry_count=00.
REQ-025 SHALL, when reset is asserted mid-sequence, drop both enables immediately, without waiting for a clock edge.

Configuration
REQ-026 SHALL, when DSP_SUPERVISOR_RETRY_EN is defined, permit a retry from COOLDOWN while retry_count<3, so FAULT is entered on the 4th failure.
REQ-027 SHALL, when DSP_SUPERVISOR_RETRY_EN is undefined, go from COOLDOWN to FAULT on the first failure, with retry_count held at 0.

Verification
REQ-028 SHALL verify this scenario: board_enable=1, dsp0 reaches on at tick 3 and dsp1 at tick 2 after BRINGUP1 -> dsp1_enable asserts exactly 4 ticks after STAGGER entry; all_on=1; fault_dsp=00.
REQ-029 SHALL verify this scenario: dsp0_state stays 0000 -> COOLDOWN at tick 20 with fault_dsp=01; with RETRY_EN, 3 retries then fault=1 and retry_count=3.
REQ-030 SHALL verify this scenario: in RUN, dsp1_state becomes 4'b1010 -> COOLDOWN next cycle, fault_dsp=10, both enables low.
REQ-031 SHALL verify this scenario: board_enable dropped in RUN -> SHUTDOWN, fault_dsp unchanged, IDLE once both states=0000.
REQ-032 SHALL verify this scenario: reset pulsed asynchronously mid-BRINGUP1 -> enables low before the next sysclk edge; sup_state=000.
REQ-033 SHALL verify this scenario: without RETRY_EN, a single BRINGUP0 timeout -> FAULT; fault clears only after board_enable=0, then returns to IDLE.

Source files
------------

// File: rtl/dsp_power_supervisor.sv
// Dual-DSP power supervisor: staggered bring-up, fault attribution, cooldown/retry and shutdown.
// Optional bring-up retries are enabled by defining DSP_SUPERVISOR_RETRY_EN.
`timescale 1ns/1ps

module dsp_power_supervisor #(
  parameter int unsigned PRESCALE_W = 13
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       board_enable,
  input  logic [3:0] dsp0_state,
  input  logic [3:0] dsp1_state,
  output logic       dsp0_enable,
  output logic       dsp1_enable,
  output logic       all_on,
  output logic       fault,
  output logic [1:0] fault_dsp,
  output logic [1:0] retry_count,
  output logic [2:0] sup_state
);

  localparam int unsigned TIMER_W = 5;
  localparam logic [TIMER_W-1:0] TIMER_MAX     = 5'd31;
  localparam logic [TIMER_W-1:0] T_BRINGUP_TO  = 5'd20;
  localparam logic [TIMER_W-1:0] T_STAGGER     = 5'd4;
  localparam logic [TIMER_W-1:0] T_COOL_MIN    = 5'd16;
  localparam logic [3:0]         DSP_ON        = 4'b1001;
  localparam logic [3:0]         DSP_OFF       = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_BRINGUP0 = 3'b001,
    ST_STAGGER  = 3'b010,
    ST_BRINGUP1 = 3'b011,
    ST_RUN      = 3'b100,
    ST_COOLDOWN = 3'b101,
    ST_FAULT    = 3'b110,
    ST_SHUTDOWN = 3'b111
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [1:0]            fault_dsp_q, fault_dsp_d;
  logic [1:0]            retry_q, retry_d;
  logic                  dsp0_en_q, dsp0_en_d;
  logic                  dsp1_en_q, dsp1_en_d;
  logic                  all_on_q, all_on_d;
  logic                  fault_q, fault_d;
  logic                  tick;
  logic                  dsp0_on, dsp1_on, both_off;
  logic                  retry_ok;

  assign presc_d  = presc_q + PRESCALE_W'(1);
  assign tick     = &presc_q;
  assign dsp0_on  = (dsp0_state == DSP_ON);
  assign dsp1_on  = (dsp1_state == DSP_ON);
  assign both_off = (dsp0_state == DSP_OFF) && (dsp1_state == DSP_OFF);

`ifdef DSP_SUPERVISOR_RETRY_EN
  assign retry_ok = (retry_q < 2'd3);
`else
  assign retry_ok = 1'b0;
`endif

  // Tick timer restarts on every state change and saturates
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      timer_q     <= '0;
      fault_dsp_q <= '0;
      retry_q     <= '0;
      dsp0_en_q   <= 1'b0;
      dsp1_en_q   <= 1'b0;
      all_on_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      fault_dsp_q <= fault_dsp_d;
      retry_q     <= retry_d;
      dsp0_en_q   <= dsp0_en_d;
      dsp1_en_q   <= dsp1_en_d;
      all_on_q    <= all_on_d;
      fault_q     <= fault_d;
    end
  end

  // Next state, fault attribution and retry bookkeeping; board_enable drop wins
  always_comb begin
    state_d     = state_q;
    fault_dsp_d = fault_dsp_q;
    retry_d     = retry_q;
    case (state_q)
      ST_IDLE: begin
        fault_dsp_d = '0;
        retry_d     = '0;
        if (board_enable) state_d = ST_BRINGUP0;
      end
      ST_BRINGUP0: begin
        if (!board_enable) begin
          state_d = ST_SHUTDOWN;
        end else if (dsp0_on) begin
          state_d = ST_STAGGER;
        end else if (timer_q == T_BRINGUP_TO) begin
          fault_dsp_d[0] = 1'b1;
          state_d        = ST_COOLDOWN;
        end
      end
      ST_STAGGER: begin
        if (!board_enable) begin
          state_d = ST_SHUTDOWN;
        end else if (!dsp0_on) begin
          fault_dsp_d[0] = 1'b1;
          state_d        = ST_COOLDOWN;
        end else if (timer_q == T_STAGGER) begin
          state_d = ST_BRINGUP1;
        end
      end
      ST_BRINGUP1: begin
        if (!board_enable) begin
          state_d = ST_SHUTDOWN;
        end else if (!dsp0_on) begin
          fault_dsp_d[0] = 1'b1;
          state_d        = ST_COOLDOWN;
        end else if (dsp1_on) begin
          state_d = ST_RUN;
        end else if (timer_q == T_BRINGUP_TO) begin
          fault_dsp_d[1] = 1'b1;
          state_d        = ST_COOLDOWN;
        end
      end
      ST_RUN: begin
        if (!board_enable) begin
          state_d = ST_SHUTDOWN;
        end else if (!dsp0_on || !dsp1_on) begin
          fault_dsp_d = fault_dsp_q | {~dsp1_on, ~dsp0_on};
          state_d     = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (!board_enable) begin
          state_d = ST_SHUTDOWN;
        end else if (((timer_q >= T_COOL_MIN) && both_off) || (timer_q == TIMER_MAX)) begin
          if (retry_ok) begin
            retry_d = retry_q + 2'(1);
            state_d = ST_BRINGUP0;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (!board_enable) state_d = ST_IDLE;
      end
      ST_SHUTDOWN: begin
        if (both_off || (timer_q == TIMER_MAX)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs track sup_state
  always_comb begin
    dsp0_en_d = 1'b0;
    dsp1_en_d = 1'b0;
    all_on_d  = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      ST_BRINGUP0,
      ST_STAGGER:  dsp0_en_d = 1'b1;
      ST_BRINGUP1: begin
        dsp0_en_d = 1'b1;
        dsp1_en_d = 1'b1;
      end
      ST_RUN: begin
        dsp0_en_d = 1'b1;
        dsp1_en_d = 1'b1;
        all_on_d  = 1'b1;
      end
      ST_FAULT:    fault_d = 1'b1;
      default:     ;
    endcase
  end

  assign dsp0_enable = dsp0_en_q;
  assign dsp1_enable = dsp1_en_q;
  assign all_on      = all_on_q;
  assign fault       = fault_q;
  assign fault_dsp   = fault_dsp_q;
  assign retry_count = retry_q;
  assign sup_state   = state_q;

endmodule

// File: tb/tb_dsp_power_supervisor.sv
// Directed bench for dsp_power_supervisor; short prescaler (16 cycles/tick) keeps timeouts quick.
`timescale 1ns/1ps

module tb_dsp_power_supervisor;

  localparam int unsigned TB_PW = 4;
  localparam int TICK = 16;
  localparam logic [2:0] S_IDLE = 3'b000, S_B0 = 3'b001, S_STAG = 3'b010, S_B1 = 3'b011,
                         S_RUN = 3'b100, S_COOL = 3'b101, S_FAULT = 3'b110, S_SHUT = 3'b111;
  localparam logic [3:0] ON = 4'b1001, OFF = 4'b0000;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       board_enable = 1'b0;
  logic [3:0] dsp0_state = OFF;
  logic [3:0] dsp1_state = OFF;
  logic       dsp0_enable, dsp1_enable, all_on, fault;
  logic [1:0] fault_dsp, retry_count;
  logic [2:0] sup_state;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n;
  int e_mark;
  int exp_edge;

  dsp_power_supervisor #(.PRESCALE_W(TB_PW)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .board_enable (board_enable),
    .dsp0_state   (dsp0_state),
    .dsp1_state   (dsp1_state),
    .dsp0_enable  (dsp0_enable),
    .dsp1_enable  (dsp1_enable),
    .all_on       (all_on),
    .fault        (fault),
    .fault_dsp    (fault_dsp),
    .retry_count  (retry_count),
    .sup_state    (sup_state)
  );

  always #5 sysclk = ~sysclk;

  // Edges since reset release; ticks land on edges that are multiples of TICK
  always @(posedge sysclk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] exp, input int budget, input string tag);
    int i = 0;
    while (sup_state !== exp && i < budget) begin
      @(negedge sysclk);
      i++;
    end
    chk(tag, 32'(sup_state), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge sysclk);
    chk("rst_state", 32'(sup_state), 32'(S_IDLE));
    chk("rst_en0", 32'(dsp0_enable), 32'd0);
    chk("rst_en1", 32'(dsp1_enable), 32'd0);
    chk("rst_allon", 32'(all_on), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fdsp", 32'(fault_dsp), 32'd0);
    chk("rst_retry", 32'(retry_count), 32'd0);

    // Normal staggered bring-up
    board_enable = 1'b1;
    @(negedge sysclk);
    chk("b0_state", 32'(sup_state), 32'(S_B0));
    chk("b0_en0", 32'(dsp0_enable), 32'd1);
    chk("b0_en1", 32'(dsp1_enable), 32'd0);
    repeat (3 * TICK - 1) @(negedge sysclk);
    dsp0_state = ON;
    wait_st(S_STAG, 4, "stag_enter");
    e_mark = edge_n;
    chk("stag_en1", 32'(dsp1_enable), 32'd0);
    exp_edge = (e_mark / TICK + 4) * TICK + 1;
    wait_st(S_B1, 100, "b1_enter");
    chk("stag_len", 32'(edge_n), 32'(exp_edge));
    chk("b1_en1", 32'(dsp1_enable), 32'd1);
    repeat (2 * TICK) @(negedge sysclk);
    dsp1_state = ON;
    wait_st(S_RUN, 4, "run_enter");
    chk("run_allon", 32'(all_on), 32'd1);
    chk("run_fdsp", 32'(fault_dsp), 32'd0);
    chk("run_en", 32'({dsp1_enable, dsp0_enable}), 32'd3);

    // DSP1 leaves on while running
    dsp1_state = 4'b1010;
    @(negedge sysclk);
    chk("rf_state", 32'(sup_state), 32'(S_COOL));
    chk("rf_fdsp", 32'(fault_dsp), 32'b10);
    chk("rf_en", 32'({dsp1_enable, dsp0_enable}), 32'd0);
    chk("rf_allon", 32'(all_on), 32'd0);
    dsp0_state = OFF;
    dsp1_state = OFF;
`ifdef DSP_SUPERVISOR_RETRY_EN
    wait_st(S_B0, 400, "rf_retry");
    chk("rf_retry_cnt", 32'(retry_count), 32'd1);
`else
    wait_st(S_FAULT, 400, "rf_fault");
    chk("rf_fault_o", 32'(fault), 32'd1);
    chk("rf_retry_cnt", 32'(retry_count), 32'd0);
`endif
    chk("rf_fdsp_sticky", 32'(fault_dsp), 32'b10);
    board_enable = 1'b0;
    wait_st(S_IDLE, 50, "rf_idle");
    @(negedge sysclk);
    chk("rf_idle_fdsp", 32'(fault_dsp), 32'd0);
    chk("rf_idle_fault", 32'(fault), 32'd0);

    // board_enable drop in RUN beats a simultaneous DSP1 fault
    do_reset();
    dsp0_state = ON;
    dsp1_state = ON;
    board_enable = 1'b1;
    wait_st(S_RUN, 120, "sd_run");
    board_enable = 1'b0;
    dsp1_state = 4'b1010;
    @(negedge sysclk);
    chk("sd_state", 32'(sup_state), 32'(S_SHUT));
    chk("sd_fdsp", 32'(fault_dsp), 32'd0);
    chk("sd_en", 32'({dsp1_enable, dsp0_enable}), 32'd0);
    chk("sd_allon", 32'(all_on), 32'd0);
    repeat (5) @(negedge sysclk);
    chk("sd_hold", 32'(sup_state), 32'(S_SHUT));
    dsp0_state = OFF;
    dsp1_state = OFF;
    @(negedge sysclk);
    chk("sd_idle", 32'(sup_state), 32'(S_IDLE));

    // Asynchronous reset in BRINGUP1
    do_reset();
    dsp0_state = ON;
    board_enable = 1'b1;
    wait_st(S_B1, 120, "ar_b1");
    chk("ar_en_pre", 32'({dsp1_enable, dsp0_enable}), 32'd3);
    @(posedge sysclk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_en", 32'({dsp1_enable, dsp0_enable}), 32'd0);
    chk("ar_state", 32'(sup_state), 32'(S_IDLE));
    board_enable = 1'b0;
    dsp0_state = OFF;
    @(negedge sysclk);

    // DSP0 never comes up: timeout, optional retries, then latched fault
    do_reset();
    board_enable = 1'b1;
    wait_st(S_B0, 4, "to_b0");
    e_mark = edge_n;
    exp_edge = (e_mark / TICK + 20) * TICK + 1;
    wait_st(S_COOL, 400, "to_cool");
    chk("to_edge", 32'(edge_n), 32'(exp_edge));
    chk("to_fdsp", 32'(fault_dsp), 32'b01);
    chk("to_en", 32'({dsp1_enable, dsp0_enable}), 32'd0);
`ifdef DSP_SUPERVISOR_RETRY_EN
    for (int r = 1; r <= 3; r++) begin
      wait_st(S_B0, 400, "to_retry_b0");
      chk("to_retry_cnt", 32'(retry_count), 32'(r));
      wait_st(S_COOL, 400, "to_retry_cool");
    end
`endif
    wait_st(S_FAULT, 400, "to_fault");
    chk("to_fault_o", 32'(fault), 32'd1);
`ifdef DSP_SUPERVISOR_RETRY_EN
    chk("to_retry_final", 32'(retry_count), 32'd3);
`else
    chk("to_retry_final", 32'(retry_count), 32'd0);
`endif
    repeat (40) @(negedge sysclk);
    chk("to_fault_hold", 32'(sup_state), 32'(S_FAULT));
    board_enable = 1'b0;
    @(negedge sysclk);
    chk("to_idle", 32'(sup_state), 32'(S_IDLE));
    chk("to_fault_clr", 32'(fault), 32'd0);
    @(negedge sysclk);
    chk("to_fdsp_clr", 32'(fault_dsp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
